// File: rtl/fetch_pc_ctrl.sv
// F-stage PC register and next-fetch-address selection for the pipelined MIPS core.
// Also produces the link address, the fetch address-error flag, the branch-delay flag and the F-stage kill.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6FFC,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic [31:0] epc,
    input  logic [31:0] d_pc,
    input  logic [2:0]  d_op,
    input  logic        d_cmp,
    input  logic [15:0] d_imm16,
    input  logic [25:0] d_idx26,
    input  logic [31:0] d_rs,
    output logic [31:0] f_pc,
    output logic [31:0] d_link,
    output logic        f_adel,
    output logic        f_bd,
    output logic        flush_f
);

    typedef enum logic [2:0] {
        OP_SEQ  = 3'b000,
        OP_BR   = 3'b001,
        OP_J    = 3'b010,
        OP_JR   = 3'b011,
        OP_ERET = 3'b100
    } d_op_e;

    logic [31:0] pc_q, pc_d;
    logic [31:0] d_pc4, br_tgt, j_tgt;
    logic        is_br, is_j, is_jr, is_eret;
    logic        redirect;

    always_comb begin
        is_br   = (d_op == OP_BR);
        is_j    = (d_op == OP_J);
        is_jr   = (d_op == OP_JR);
        is_eret = (d_op == OP_ERET);
        d_pc4   = d_pc + 32'd4;
        br_tgt  = d_pc4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
        j_tgt   = {d_pc4[31:28], d_idx26, 2'b00};
        // op codes 5..7 match none of the classes and fall through to sequential flow
        redirect = (is_br && d_cmp) || is_j || is_jr || is_eret;
    end

    always_comb begin
        pc_d = pc_q + 32'd4;
        if (req)                pc_d = HANDLER_PC;
        else if (stall)         pc_d = pc_q;
        else if (is_eret)       pc_d = epc;
        else if (is_jr)         pc_d = d_rs;
        else if (is_j)          pc_d = j_tgt;
        else if (is_br && d_cmp) pc_d = br_tgt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    always_comb begin
        f_pc    = pc_q;
        d_link  = d_pc + (DELAY_SLOT ? 32'd8 : 32'd4);
        f_adel  = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);
        f_bd    = DELAY_SLOT && (is_br || is_j || is_jr);
        // exception entry flushes through CP0, so req suppresses the local kill
        flush_f = !req && !stall && (is_eret || (!DELAY_SLOT && redirect));
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: both delay-slot modes side by side against a behavioural model,
// directed pinning sequences followed by randomized traffic with occasional async resets.
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, req, d_cmp;
    logic [31:0] epc, d_pc, d_rs;
    logic [2:0]  d_op;
    logic [15:0] d_imm16;
    logic [25:0] d_idx26;

    logic [31:0] f_pc1, d_link1, f_pc0, d_link0;
    logic        f_adel1, f_bd1, flush_f1, f_adel0, f_bd0, flush_f0;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_pc;
    bit          model_on = 1'b0;

    always #5 clk = ~clk;

    fetch_pc_ctrl #(.DELAY_SLOT(1'b1)) u_ds1 (
        .clk(clk), .reset(reset), .stall(stall), .req(req), .epc(epc), .d_pc(d_pc),
        .d_op(d_op), .d_cmp(d_cmp), .d_imm16(d_imm16), .d_idx26(d_idx26), .d_rs(d_rs),
        .f_pc(f_pc1), .d_link(d_link1), .f_adel(f_adel1), .f_bd(f_bd1), .flush_f(flush_f1)
    );

    fetch_pc_ctrl #(.DELAY_SLOT(1'b0)) u_ds0 (
        .clk(clk), .reset(reset), .stall(stall), .req(req), .epc(epc), .d_pc(d_pc),
        .d_op(d_op), .d_cmp(d_cmp), .d_imm16(d_imm16), .d_idx26(d_idx26), .d_rs(d_rs),
        .f_pc(f_pc0), .d_link(d_link0), .f_adel(f_adel0), .f_bd(f_bd0), .flush_f(flush_f0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req_v, $time);
        end
    endtask

    function automatic logic [31:0] model_next();
        logic [31:0] nxt;
        if (req)                       nxt = 32'h0000_4180;
        else if (stall)                nxt = exp_pc;
        else if (d_op == 3'd4)         nxt = epc;
        else if (d_op == 3'd3)         nxt = d_rs;
        else if (d_op == 3'd2)         nxt = ((d_pc + 32'd4) & 32'hF000_0000) | (32'(d_idx26) * 32'd4);
        else if (d_op == 3'd1 && d_cmp) nxt = d_pc + 32'd4 + 32'(int'($signed(d_imm16)) * 4);
        else                           nxt = exp_pc + 32'd4;
        return nxt;
    endfunction

    function automatic logic model_adel(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
    endfunction

    function automatic logic model_flush(input bit ds);
        logic taken;
        taken = (d_op == 3'd1 && d_cmp) || d_op == 3'd2 || d_op == 3'd3 || d_op == 3'd4;
        return !req && !stall && (d_op == 3'd4 || (!ds && taken));
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) exp_pc <= 32'h0000_3000;
        else        exp_pc <= model_next();
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("pc_ds1",    f_pc1,    exp_pc);
            chk("pc_ds0",    f_pc0,    exp_pc);
            chk("link_ds1",  d_link1,  d_pc + 32'd8);
            chk("link_ds0",  d_link0,  d_pc + 32'd4);
            chk("adel_ds1",  32'(f_adel1), 32'(model_adel(exp_pc)));
            chk("adel_ds0",  32'(f_adel0), 32'(model_adel(exp_pc)));
            chk("bd_ds1",    32'(f_bd1),   32'(d_op == 3'd1 || d_op == 3'd2 || d_op == 3'd3));
            chk("bd_ds0",    32'(f_bd0),   32'd0);
            chk("flush_ds1", 32'(flush_f1), 32'(model_flush(1'b1)));
            chk("flush_ds0", 32'(flush_f0), 32'(model_flush(1'b0)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] tgt [4];
        logic        tgt_adel [4];
        tgt[0] = 32'h0000_3002; tgt_adel[0] = 1'b1;
        tgt[1] = 32'h0000_7000; tgt_adel[1] = 1'b1;
        tgt[2] = 32'h0000_6FFC; tgt_adel[2] = 1'b0;
        tgt[3] = 32'h0000_2FFC; tgt_adel[3] = 1'b1;

        reset = 1'b0; stall = 1'b0; req = 1'b0; d_cmp = 1'b0; epc = '0; d_pc = '0;
        d_rs = '0; d_op = '0; d_imm16 = '0; d_idx26 = '0;

        repeat (3) begin
            step();
            model_on = 1'b1;
            chk("lit_rst_pc1", f_pc1, 32'h3000);
            chk("lit_rst_pc0", f_pc0, 32'h3000);
        end
        chk("lit_rst_link1", d_link1, 32'd8);
        chk("lit_rst_adel",  32'(f_adel1), 32'd0);
        chk("lit_rst_bd",    32'(f_bd1), 32'd0);
        chk("lit_rst_flush", 32'(flush_f1), 32'd0);
        reset = 1'b1;
        step(); chk("lit_seq1", f_pc1, 32'h3004);
        step(); chk("lit_seq2", f_pc1, 32'h3008);
        step(); chk("lit_seq3", f_pc1, 32'h300C);

        d_pc = 32'h3010; d_op = 3'd1; d_cmp = 1'b1; d_imm16 = 16'hFFFC;
        #1;
        chk("lit_br_bd1",    32'(f_bd1), 32'd1);
        chk("lit_br_flush1", 32'(flush_f1), 32'd0);
        chk("lit_br_link1",  d_link1, 32'h3018);
        chk("lit_br_flush0", 32'(flush_f0), 32'd1);
        chk("lit_br_link0",  d_link0, 32'h3014);
        step(); chk("lit_br_pc", f_pc0, 32'h3004);
        d_cmp = 1'b0;
        #1;
        chk("lit_nt_flush0", 32'(flush_f0), 32'd0);
        step(); chk("lit_nt_pc", f_pc1, 32'h3008);

        d_op = 3'd3; d_rs = 32'h3050; stall = 1'b1;
        step(); chk("lit_jr_hold1", f_pc1, 32'h3008);
        step(); chk("lit_jr_hold2", f_pc0, 32'h3008);
        stall = 1'b0;
        step(); chk("lit_jr_pc", f_pc1, 32'h3050);

        req = 1'b1; stall = 1'b1; d_op = 3'd2; d_idx26 = 26'h123;
        #1;
        chk("lit_req_flush0", 32'(flush_f0), 32'd0);
        step(); chk("lit_req_pc", f_pc0, 32'h4180);
        req = 1'b0; stall = 1'b0;

        d_op = 3'd4; epc = 32'h3024;
        #1;
        chk("lit_eret_flush1", 32'(flush_f1), 32'd1);
        chk("lit_eret_flush0", 32'(flush_f0), 32'd1);
        chk("lit_eret_bd1",    32'(f_bd1), 32'd0);
        step(); chk("lit_eret_pc", f_pc1, 32'h3024);

        for (int i = 0; i < 4; i++) begin
            d_op = 3'd3; d_rs = tgt[i];
            step(); chk("lit_adel_pc", f_pc1, tgt[i]);
            d_op = 3'd0;
            #1;
            chk("lit_adel", 32'(f_adel0), 32'(tgt_adel[i]));
            step(); chk("lit_adel_next", f_pc0, tgt[i] + 32'd4);
        end
        chk("lit_lo_ok", 32'(f_adel1), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            step();
            reset   = ($urandom_range(0, 96) != 0);
            stall   = ($urandom_range(0, 4) == 0);
            req     = ($urandom_range(0, 16) == 0);
            d_op    = 3'($urandom_range(0, 7));
            d_cmp   = 1'($urandom);
            d_pc    = 32'h3000 + (32'($urandom_range(0, 32'hFFF)) << 2);
            d_imm16 = 16'($urandom);
            d_idx26 = 26'($urandom);
            epc     = 32'h3000 + (32'($urandom_range(0, 32'hFFF)) << 2);
            case ($urandom_range(0, 2))
                0:       d_rs = $urandom;
                1:       d_rs = 32'h2FF8 + 32'($urandom_range(0, 12));
                default: d_rs = 32'h6FF8 + 32'($urandom_range(0, 12));
            endcase
        end
        reset = 1'b1;
        step();
        model_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
